// File: rtl/img_pkg.sv
// Shared widths, sync bytes and FSM encoding for the image path.
// The ram and UART-RX blocks use the same widths and sync bytes.
package img_pkg;

  localparam int PIX_W  = 12;
  localparam int ADDR_W = 15;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_FIN
  } state_t;

  function automatic int bit_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first; every bit lasts BIT_DIV clocks.
// A load is taken only on a cycle where tx_ready=1; the start bit begins the next cycle.
module uart_tx_byte #(
  parameter int BIT_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx
);

  localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BIT_DIV - 2);
  localparam logic [3:0]       STOP_IDX = 4'd9;

  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       bit_idx;
  logic [9:0]       shreg;

  // The line is the bottom flop of the shift register; all-ones means idle/stop.
  assign tx = shreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '1;
      tx_ready <= 1'b1;
    end else if (tx_ready) begin
      if (tx_load) begin
        shreg    <= {1'b1, tx_data, 1'b0};
        bit_cnt  <= '0;
        bit_idx  <= '0;
        tx_ready <= 1'b0;
      end
    end else begin
      if (bit_cnt == CNT_LAST) begin
        bit_cnt <= '0;
        bit_idx <= bit_idx + 4'd1;
        shreg   <= {1'b1, shreg[9:1]};
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      // Ready is raised for the final clock of the stop bit so bytes can abut.
      if (bit_idx == STOP_IDX && bit_cnt == CNT_PRE)
        tx_ready <= 1'b1;
    end
  end

endmodule

// File: rtl/img_uart_tx.sv
// Streams the stored RGB444 frame from SPRAM over UART: two sync bytes,
// then each pixel as {4'h0,R} and {G,B}.
module img_uart_tx
  import img_pkg::*;
#(
  parameter int         CLK_FREQ = 50000000,
  parameter int         BAUD     = 115200,
  parameter int         PIX_NUM  = 19200,
  parameter logic [7:0] HDR0     = HDR0_DEF,
  parameter logic [7:0] HDR1     = HDR1_DEF
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_spram_rd_req,
  output logic [ADDR_W-1:0] o_spram_addr,
  input  logic              i_spram_gnt,
  input  logic [PIX_W-1:0]  i_spram_rd_data,
  output logic              o_uart_tx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int                BIT_DIV   = bit_div(CLK_FREQ, BAUD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_NUM - 1);

  state_t             state;
  logic [ADDR_W-1:0]  pix_cnt;
  logic [PIX_W-1:0]   pix;
  logic               tx_ready;
  logic               tx_load;
  logic               send_state;
  logic [7:0]         tx_data;

  // Abort is honoured before a load, so an aborting send state never starts a byte.
  assign send_state     = (state == ST_HDR0) || (state == ST_HDR1) ||
                          (state == ST_SEND_HI) || (state == ST_SEND_LO);
  assign tx_load        = send_state && tx_ready && !i_abort;
  assign o_spram_rd_req = (state == ST_RD_REQ) && !i_abort;
  assign o_spram_addr   = pix_cnt;
  assign o_busy         = (state != ST_IDLE);

  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_HDR0:    tx_data = HDR0;
      ST_HDR1:    tx_data = HDR1;
      ST_SEND_HI: tx_data = {4'h0, pix[11:8]};
      ST_SEND_LO: tx_data = pix[7:0];
      default:    tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      pix_cnt <= '0;
      pix     <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: if (i_start) begin
          state   <= ST_HDR0;
          pix_cnt <= '0;
        end
        ST_HDR0:    if (tx_ready) state <= i_abort ? ST_IDLE : ST_HDR1;
        ST_HDR1:    if (tx_ready) state <= i_abort ? ST_IDLE : ST_RD_REQ;
        ST_RD_REQ: begin
          if (i_abort)          state <= ST_IDLE;
          else if (i_spram_gnt) state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          pix   <= i_spram_rd_data;
          state <= ST_SEND_HI;
        end
        ST_SEND_HI: if (tx_ready) state <= i_abort ? ST_IDLE : ST_SEND_LO;
        // Terminal compare precedes the increment so the counter never wraps.
        ST_SEND_LO: if (tx_ready) begin
          if (i_abort)                   state <= ST_IDLE;
          else if (pix_cnt == LAST_ADDR) state <= ST_FIN;
          else begin
            pix_cnt <= pix_cnt + 1'b1;
            state   <= ST_RD_REQ;
          end
        end
        ST_FIN: if (tx_ready) begin
          o_done <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.BIT_DIV(BIT_DIV)) u_tx_byte (
    .clk      (i_clk_sys),
    .rst_n    (i_rst_n),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx       (o_uart_tx)
  );

endmodule
